// File: rtl/plc_pkg.sv
// Shared types and constants for the pipelined logic cloud.
package plc_pkg;

  // Logic function applied by the compute stage to each beat.
  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_ACC = 2'b11
  } mode_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/plc_pipe_reg.sv
// Valid-qualified delay line of DEPTH stages. Each stage's data register
// only loads when the beat entering it is valid, so bubbles leave the last
// valid payload in place. Synchronous active-low reset clears everything.
module plc_pipe_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    if (gi == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_link
      assign src_valid = stage[gi-1].valid_reg;
      assign src_data  = stage[gi-1].data_reg;
    end

    // Advance the valid bit every cycle; load data only on valid beats.
    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= src_valid;
        if (src_valid) begin
          data_reg <= src_data;
        end
      end
    end
  end

  assign out_valid = stage[DEPTH-1].valid_reg;
  assign out_data  = stage[DEPTH-1].data_reg;

endmodule

// File: rtl/pipelined_logic_cloud.sv
// Pipelined logic cloud: captures four operand buses, applies a per-beat
// AND/XOR/OR function (or an XOR accumulator), delays the results through
// DEPTH output stages and counts nonzero result beats with saturation.
// Optional macro PARITY_OUT_EN adds a registered out_par = ^out1 output.
module pipelined_logic_cloud
  import plc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic             clr_acc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
`ifdef PARITY_OUT_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] hit_cnt
);

`ifdef PARITY_OUT_EN
  localparam int PW = 2 * WIDTH + 1;
`else
  localparam int PW = 2 * WIDTH;
`endif

  logic [WIDTH-1:0] q1_reg, q2_reg, q3_reg, q4_reg;
  mode_t            mode_reg;
  logic             v0_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] hit_cnt_reg;

  logic [WIDTH-1:0] a, x, t, acc_next, r1, r2;
  logic [PW-1:0]    pipe_in, pipe_out;
  logic             hit;

  // Stage 0: capture operands and mode on valid beats, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q1_reg   <= '0;
      q2_reg   <= '0;
      q3_reg   <= '0;
      q4_reg   <= '0;
      mode_reg <= MODE_OR;
      v0_reg   <= 1'b0;
    end else begin
      v0_reg <= in_valid;
      if (in_valid) begin
        q1_reg   <= in1;
        q2_reg   <= in2;
        q3_reg   <= in3;
        q4_reg   <= in4;
        mode_reg <= mode_t'(mode);
      end
    end
  end

  // Stage 1: logic cloud; a same-cycle clear is applied before accumulating.
  always_comb begin
    a        = q1_reg & q3_reg;
    x        = q2_reg ^ q4_reg;
    t        = a | x;
    acc_next = (clr_acc ? '0 : acc_reg) ^ t;
    r1       = a | x;
    r2       = ~a;
    case (mode_reg)
      MODE_OR: begin
        r1 = a | x;
        r2 = ~a;
      end
      MODE_AND: begin
        r1 = a & x;
        r2 = ~x;
      end
      MODE_XOR: begin
        r1 = a ^ x;
        r2 = ~(a | x);
      end
      MODE_ACC: begin
        r1 = acc_next;
        r2 = ~acc_next;
      end
      default: ;
    endcase
  end

  // Accumulator: only valid accumulate beats, clr_acc and reset touch it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (v0_reg && (mode_reg == MODE_ACC)) begin
      acc_reg <= acc_next;
    end else if (clr_acc) begin
      acc_reg <= '0;
    end
  end

`ifdef PARITY_OUT_EN
  assign pipe_in = {^r1, r1, r2};
  assign out_par = pipe_out[PW-1];
`else
  assign pipe_in = {r1, r2};
`endif

  plc_pipe_reg #(
    .WIDTH(PW),
    .DEPTH(DEPTH)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v0_reg),
    .in_data  (pipe_in),
    .out_valid(out_valid),
    .out_data (pipe_out)
  );

  assign out1 = pipe_out[2*WIDTH-1:WIDTH];
  assign out2 = pipe_out[WIDTH-1:0];

  assign hit = out_valid && (out1 != '0);

  // Saturating hit counter; a clear restarts it, keeping a coincident hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_reg <= '0;
    end else if (clr_acc) begin
      hit_cnt_reg <= CNT_W'(hit);
    end else if (hit && !(&hit_cnt_reg)) begin
      hit_cnt_reg <= hit_cnt_reg + 1'b1;
    end
  end

  assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_pipelined_logic_cloud.sv
// Directed testbench for pipelined_logic_cloud (WIDTH=8, DEPTH=1, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_pipelined_logic_cloud;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [1:0]       mode;
  logic [WIDTH-1:0] in1, in2, in3, in4;
  logic             clr_acc;
  logic             out_valid;
  logic [WIDTH-1:0] out1, out2;
  logic [CNT_W-1:0] hit_cnt;
`ifdef PARITY_OUT_EN
  logic             out_par;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_logic_cloud #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .mode     (mode),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .clr_acc  (clr_acc),
    .out_valid(out_valid),
    .out1     (out1),
    .out2     (out2),
`ifdef PARITY_OUT_EN
    .out_par  (out_par),
`endif
    .hit_cnt  (hit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1);
    in_valid = 1'b1;
    mode     = m;
    in1      = a0;
    in2      = b0;
    in3      = a1;
    in4      = b1;
    $display("beat mode=%0d in1=%h in2=%h in3=%h in4=%h", m, a0, b0, a1, b1);
  endtask

  initial begin
    rst      = 1'b0;
    clr_acc  = 1'b0;
    in_valid = 1'b1;
    mode     = 2'($urandom_range(0, 3));
    in1      = 8'($urandom);
    in2      = 8'($urandom);
    in3      = 8'($urandom);
    in4      = 8'($urandom);
    #2;

    // Reset with junk valid beats present.
    step();
    in1 = 8'($urandom);
    in3 = 8'($urandom);
    step();
    chk("rst_out1", 32'(out1), 32'h00);
    chk("rst_out2", 32'(out2), 32'h00);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_hit", 32'(hit_cnt), 32'h0);
`ifdef PARITY_OUT_EN
    chk("rst_par", 32'(out_par), 32'h0);
`endif
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    chk("post_rst_ov1", 32'(out_valid), 32'h0);
    step();
    chk("post_rst_ov2", 32'(out_valid), 32'h0);

    // Mode 00: a=C0, x=F0 -> out1=F0, out2=3F two edges after driving.
    drive(2'b00, 8'hF0, 8'h0F, 8'hCC, 8'hFF);
    step();
    in_valid = 1'b0;
    chk("m0_ov_early", 32'(out_valid), 32'h0);
    step();
    chk("m0_ov", 32'(out_valid), 32'h1);
    chk("m0_out1", 32'(out1), 32'hF0);
    chk("m0_out2", 32'(out2), 32'h3F);
`ifdef PARITY_OUT_EN
    chk("m0_par", 32'(out_par), 32'h0);
`endif
    step();
    chk("m0_ov_drop", 32'(out_valid), 32'h0);
    chk("m0_hold", 32'(out1), 32'hF0);
    chk("m0_hit", 32'(hit_cnt), 32'h1);

    // Mode 11: three back-to-back beats with t=01 -> 01, 00, 01.
    drive(2'b11, 8'hFF, 8'h00, 8'h01, 8'h00);
    step();
    drive(2'b11, 8'hFF, 8'h00, 8'h01, 8'h00);
    step();
    chk("acc1_ov", 32'(out_valid), 32'h1);
    chk("acc1_out1", 32'(out1), 32'h01);
    chk("acc1_out2", 32'(out2), 32'hFE);
`ifdef PARITY_OUT_EN
    chk("acc1_par", 32'(out_par), 32'h1);
`endif
    drive(2'b11, 8'hFF, 8'h00, 8'h01, 8'h00);
    step();
    in_valid = 1'b0;
    chk("acc2_out1", 32'(out1), 32'h00);
    chk("acc2_out2", 32'(out2), 32'hFF);
    chk("acc_hit_mid", 32'(hit_cnt), 32'h2);
    step();
    chk("acc3_out1", 32'(out1), 32'h01);
    chk("acc3_out2", 32'(out2), 32'hFE);
    step();
    chk("acc_hit", 32'(hit_cnt), 32'h3);
    step();
    step();

    // Clear collision: acc=01, beat with t=02 while clr_acc at stage 1.
    drive(2'b11, 8'h02, 8'h00, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    clr_acc  = 1'b1;
    step();
    clr_acc = 1'b0;
    chk("col_out1", 32'(out1), 32'h02);
    chk("col_out2", 32'(out2), 32'hFD);
    chk("col_hit_clr", 32'(hit_cnt), 32'h0);
    step();
    chk("col_hit", 32'(hit_cnt), 32'h1);
    // acc must now be 02: accumulate t=01 -> 03.
    drive(2'b11, 8'h01, 8'h00, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk("col_acc", 32'(out1), 32'h03);
    step();
    chk("col_hit2", 32'(hit_cnt), 32'h2);

    // Bubble hold: mode 01 beat, three idle cycles, mode 10 beat.
    drive(2'b01, 8'hF0, 8'h0F, 8'hCC, 8'hFF);
    step();
    in_valid = 1'b0;
    step();
    chk("bub1_ov", 32'(out_valid), 32'h1);
    chk("bub1_out1", 32'(out1), 32'hC0);
    chk("bub1_out2", 32'(out2), 32'h0F);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bub_idle_ov", 32'(out_valid), 32'h0);
      chk("bub_idle_out1", 32'(out1), 32'hC0);
      chk("bub_idle_out2", 32'(out2), 32'h0F);
    end
    drive(2'b10, 8'hF0, 8'h0F, 8'hCC, 8'hFF);
    step();
    in_valid = 1'b0;
    chk("bub_idle_ov3", 32'(out_valid), 32'h0);
    chk("bub_idle_out1_3", 32'(out1), 32'hC0);
    step();
    chk("bub2_ov", 32'(out_valid), 32'h1);
    chk("bub2_out1", 32'(out1), 32'h30);
    chk("bub2_out2", 32'(out2), 32'h0F);

    // Non-accumulate modes leave acc at 03: a t=00 accumulate beat shows it.
    drive(2'b11, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk("acc_untouched", 32'(out1), 32'h03);
    step();
    step();

    // clr_acc alone clears hit_cnt and acc.
    clr_acc = 1'b1;
    step();
    clr_acc = 1'b0;
    chk("clr_hit", 32'(hit_cnt), 32'h0);
    drive(2'b11, 8'h01, 8'h00, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk("clr_acc_out", 32'(out1), 32'h01);
    step();
    step();
    clr_acc = 1'b1;
    step();
    clr_acc = 1'b0;
    chk("sat_start", 32'(hit_cnt), 32'h0);

    // Saturation: 20 back-to-back nonzero beats; counter sticks at F.
    for (int i = 1; i <= 22; i++) begin
      int exp_cnt;
      if (i <= 20) begin
        drive(2'b00, 8'hF0, 8'h0F, 8'hCC, 8'hFF);
      end else begin
        in_valid = 1'b0;
      end
      step();
      exp_cnt = (i > 2) ? i - 2 : 0;
      if (exp_cnt > 15) exp_cnt = 15;
      chk($sformatf("sat_hit_%0d", i), 32'(hit_cnt), 32'(exp_cnt));
    end
    in_valid = 1'b0;
    step();
    chk("sat_final", 32'(hit_cnt), 32'hF);
    chk("sat_out1", 32'(out1), 32'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
